// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Bus-slave UART receiver. It deserialises 8N1 frames from the asynchronous
//   RX pin into a small circular FIFO. It exposes control, status, baud
//   divisor and receive-data registers. It raises a level interrupt while
//   received data is pending and the interrupt is enabled.
//
//   Optional feature macro: UART_RX_PARITY_EN
//     When defined, the block adds CTRL[2] parity_en and STATUS[4] parity_err
//     (sticky, write-1-to-clear). It also adds an even-parity bit state
//     between the data bits and the stop bit.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   HSEL       slave select
//   HADDR      address, only [3:0] decoded
//   HWRITE     1 = write, 0 = read
//   HWDATA     write data
//   HRDATA     read data, combinational while HSEL, otherwise 0
//   RX         asynchronous serial input, idle high
//   interrupt  registered level interrupt (irq_en & not_empty)
//
// Register map (HADDR[3:0])
//   0x0 CTRL    [0] rx_en, [1] irq_en, [2] parity_en (macro only)
//   0x4 STATUS  [0] not_empty, [1] full, [2] overrun W1C, [3] frame_err W1C,
//               [4] parity_err W1C (macro only)
//   0x8 BAUD    [15:0] clk cycles per bit; writes below 4 are clamped to 4
//   0xC RXDATA  [7:0] head byte; the first cycle of a read pops the byte
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RST   = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    input  logic        RX,
    output logic        interrupt
);

    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;

    // Even parity over the data byte: 1 when the byte has an odd number of ones.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [3:0] addr_s;
    logic       wr_s;
    logic       rd_data_s;
    logic       sts_wr_s;
    logic       unused_s;

    assign addr_s    = HADDR[3:0];
    assign wr_s      = HSEL & HWRITE;
    assign rd_data_s = HSEL & ~HWRITE & (addr_s == 4'hC);
    assign sts_wr_s  = wr_s & (addr_s == 4'h4);
    assign unused_s  = ^{HADDR[31:4], HWDATA[31:16]};

    // ------------------------------------------------------------------
    // Control and baud registers
    // ------------------------------------------------------------------
    logic        rx_en_r;
    logic        irq_en_r;
    logic [15:0] baud_r;
`ifdef UART_RX_PARITY_EN
    logic        parity_en_r;
`endif

    // CTRL and BAUD register writes; BAUD is clamped so half-bit timing stays sane.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_en_r     <= 1'b0;
            irq_en_r    <= 1'b0;
            baud_r      <= BAUD_RST;
`ifdef UART_RX_PARITY_EN
            parity_en_r <= 1'b0;
`endif
        end else begin
            if (wr_s && (addr_s == 4'h0)) begin
                rx_en_r     <= HWDATA[0];
                irq_en_r    <= HWDATA[1];
`ifdef UART_RX_PARITY_EN
                parity_en_r <= HWDATA[2];
`endif
            end
            if (wr_s && (addr_s == 4'h8)) begin
                baud_r <= (HWDATA[15:0] < 16'd4) ? 16'd4 : HWDATA[15:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // RX synchroniser and falling-edge detect
    // ------------------------------------------------------------------
    logic rx_meta_r;
    logic rx_sync_r;
    logic rx_prev_r;
    logic fall_s;

    assign fall_s = rx_prev_r & ~rx_sync_r;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // ------------------------------------------------------------------
    // Receive state machine
    // ------------------------------------------------------------------
    logic [2:0]  state_r;
    logic [2:0]  state_nxt_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_nxt_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nxt_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_nxt_s;
    logic        cnt_zero_s;
    logic [15:0] reload_s;
    logic [15:0] half_s;
    logic        push_req_s;
    logic        frame_err_set_s;
    logic        parity_err_set_s;

    assign cnt_zero_s = (cnt_r == 16'd0);
    // The counter reloads with divisor-1, so a full bit lasts exactly 'divisor' cycles.
    assign reload_s   = baud_r - 16'd1;
    assign half_s     = {1'b0, baud_r[15:1]};

    // Next-state, counter, shift register and frame-event decode.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        shift_nxt_s      = shift_r;
        idx_nxt_s        = idx_r;
        push_req_s       = 1'b0;
        frame_err_set_s  = 1'b0;
        parity_err_set_s = 1'b0;
        if (!rx_en_r) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_s) begin
                        cnt_nxt_s   = half_s;
                        state_nxt_s = ST_START;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_zero_s) begin
                        if (!rx_sync_r) begin
                            cnt_nxt_s   = reload_s;
                            idx_nxt_s   = 3'd0;
                            state_nxt_s = ST_DATA;
                        end else begin
                            // Line went back high at mid-start: treat it as a glitch.
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt_zero_s) begin
                        shift_nxt_s = {rx_sync_r, shift_r[7:1]};
                        cnt_nxt_s   = reload_s;
                        if (idx_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt_s = parity_en_r ? ST_PARITY : ST_STOP;
`else
                            state_nxt_s = ST_STOP;
`endif
                        end else begin
                            idx_nxt_s = idx_r + 3'd1;
                        end
                    end else begin
                        cnt_nxt_s = cnt_r - 16'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_zero_s) begin
                        parity_err_set_s = even_parity(shift_r) ^ rx_sync_r;
                        cnt_nxt_s        = reload_s;
                        state_nxt_s      = ST_STOP;
                    end else begin
                        cnt_nxt_s = cnt_r - 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_zero_s) begin
                        if (rx_sync_r) begin
                            push_req_s = 1'b1;
                        end else begin
                            frame_err_set_s = 1'b1;
                        end
                        state_nxt_s = ST_IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r - 16'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Receive state machine registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            shift_r <= 8'd0;
            idx_r   <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            shift_r <= shift_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic             rd_prev_r;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             overrun_set_s;

    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]) &&
                     (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]);
    // Pop only on the first cycle of an RXDATA read, so a held strobe pops once.
    assign pop_s   = rd_data_s & ~rd_prev_r & ~empty_s;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign push_s        = push_req_s & (~full_s | pop_s);
    assign overrun_set_s = push_req_s & full_s & ~pop_s;

    // FIFO storage, pointers and the read-strobe history flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'd0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            rd_prev_r <= 1'b0;
        end else begin
            rd_prev_r <= rd_data_s;
            if (push_s) begin
                mem_r[wr_ptr_r[IDX_W-1:0]] <= shift_r;
                wr_ptr_r                   <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sticky status bits and interrupt
    // ------------------------------------------------------------------
    logic overrun_r;
    logic frame_err_r;
    logic parity_err_r;
    logic interrupt_r;

    // Sticky error flags: a new event takes priority over a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_r    <= 1'b0;
            frame_err_r  <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            overrun_r    <= overrun_set_s    | (overrun_r    & ~(sts_wr_s & HWDATA[2]));
            frame_err_r  <= frame_err_set_s  | (frame_err_r  & ~(sts_wr_s & HWDATA[3]));
`ifdef UART_RX_PARITY_EN
            parity_err_r <= parity_err_set_s | (parity_err_r & ~(sts_wr_s & HWDATA[4]));
`else
            parity_err_r <= 1'b0;
`endif
        end
    end

    // Registered level interrupt: pending data and interrupt enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            interrupt_r <= 1'b0;
        end else begin
            interrupt_r <= irq_en_r & ~empty_s;
        end
    end

    assign interrupt = interrupt_r;

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] ctrl_rd_s;
    logic [31:0] status_rd_s;
    logic [31:0] rxdata_rd_s;

`ifdef UART_RX_PARITY_EN
    assign ctrl_rd_s   = {29'd0, parity_en_r, irq_en_r, rx_en_r};
`else
    assign ctrl_rd_s   = {30'd0, irq_en_r, rx_en_r};
`endif
    assign status_rd_s = {27'd0, parity_err_r, frame_err_r, overrun_r, full_s, ~empty_s};
    assign rxdata_rd_s = empty_s ? 32'd0 : {24'd0, mem_r[rd_ptr_r[IDX_W-1:0]]};

    // Combinational read data, forced to 0 when the slave is not selected.
    always_comb begin
        HRDATA = 32'd0;
        if (HSEL) begin
            case (addr_s)
                4'h0:    HRDATA = ctrl_rd_s;
                4'h4:    HRDATA = status_rd_s;
                4'h8:    HRDATA = {16'd0, baud_r};
                4'hC:    HRDATA = rxdata_rd_s;
                default: HRDATA = 32'd0;
            endcase
        end else begin
            HRDATA = 32'd0;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed self-checking bench for uart_rx_fifo. Bytes that are expected to
//   reach the FIFO go into a scoreboard queue when they are transmitted. Each
//   RXDATA read pops that queue and compares the result.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int BIT = 16;

    logic        clk;
    logic        rst;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        RX;
    logic        interrupt;

    int tests_run;
    int tests_failed;
    logic [7:0] sb_q[$];

    uart_rx_fifo #(.FIFO_DEPTH(4), .BAUD_RST(16'd434)) dut (
        .clk       (clk),
        .rst       (rst),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .RX        (RX),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        HSEL   = 1'b1;
        HWRITE = 1'b1;
        HADDR  = {28'd0, addr};
        HWDATA = data;
        @(negedge clk);
        HSEL   = 1'b0;
        HWRITE = 1'b0;
        HWDATA = 32'd0;
    endtask

    // Reads one register. The idle cycle afterwards lets the next read count as a fresh access.
    task automatic bus_read(input logic [3:0] addr, output logic [31:0] data);
        @(negedge clk);
        HSEL   = 1'b1;
        HWRITE = 1'b0;
        HADDR  = {28'd0, addr};
        #1;
        data = HRDATA;
        @(negedge clk);
        HSEL = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(addr, d);
        check(tag, d, exp);
    endtask

    // Reads RXDATA and compares it with the scoreboard head. An empty scoreboard expects 0.
    task automatic read_rx(input string tag);
        logic [31:0] d;
        logic [31:0] exp;
        bus_read(4'hC, d);
        exp = 32'd0;
        if (sb_q.size() > 0) begin
            exp = {24'd0, sb_q.pop_front()};
        end
        check(tag, d, exp);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic with_par, input logic par_bit);
        @(negedge clk);
        RX = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            RX = data[i];
            repeat (BIT) @(negedge clk);
        end
        if (with_par) begin
            RX = par_bit;
            repeat (BIT) @(negedge clk);
        end
        RX = stop_bit;
        repeat (BIT) @(negedge clk);
        RX = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  part;
        tests_run    = 0;
        tests_failed = 0;
        rst    = 1'b1;
        HSEL   = 1'b0;
        HWRITE = 1'b0;
        HADDR  = 32'd0;
        HWDATA = 32'd0;
        RX     = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_hrdata_idle", HRDATA, 32'd0);
        check_reg("rst_ctrl",   4'h0, 32'h0);
        check_reg("rst_status", 4'h4, 32'h0);
        check_reg("rst_baud",   4'h8, 32'h1B2);
        check_reg("rst_rxdata", 4'hC, 32'h0);
        check("rst_irq", {31'd0, interrupt}, 32'd0);

        // BAUD clamp and programming
        bus_write(4'h8, 32'd2);
        check_reg("baud_clamp", 4'h8, 32'd4);
        bus_write(4'h8, 32'd16);
        check_reg("baud_16", 4'h8, 32'd16);

        // Single byte with interrupt
        bus_write(4'h0, 32'h3);
        sb_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check("a5_irq", {31'd0, interrupt}, 32'd1);
        check_reg("a5_status", 4'h4, 32'h1);
        check("idle_hrdata_pending", HRDATA, 32'd0);
        read_rx("a5_data");
        check_reg("a5_status_after", 4'h4, 32'h0);
        check("a5_irq_after", {31'd0, interrupt}, 32'd0);

        // Overrun with irq disabled: the fifth byte is dropped
        bus_write(4'h0, 32'h1);
        for (int i = 1; i <= 5; i++) begin
            part = 8'(i);
            if (i <= 4) begin
                sb_q.push_back(part);
            end
            send_frame(part, 1'b1, 1'b0, 1'b0);
        end
        check_reg("ovr_status", 4'h4, 32'h7);
        check("ovr_irq_masked", {31'd0, interrupt}, 32'd0);

        // A strobe held for three cycles pops once
        @(negedge clk);
        HSEL   = 1'b1;
        HWRITE = 1'b0;
        HADDR  = 32'hC;
        #1;
        check("held_first", HRDATA, {24'd0, sb_q.pop_front()});
        repeat (3) @(negedge clk);
        HSEL = 1'b0;
        @(negedge clk);
        read_rx("ovr_data2");
        read_rx("ovr_data3");
        read_rx("ovr_data4");
        read_rx("ovr_empty_read");
        check_reg("ovr_status_drained", 4'h4, 32'h4);
        bus_write(4'h4, 32'h4);
        check_reg("ovr_cleared", 4'h4, 32'h0);

        // Frame error: stop bit low, byte discarded
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check_reg("ferr_status", 4'h4, 32'h8);
        read_rx("ferr_empty");
        bus_write(4'h4, 32'h8);
        check_reg("ferr_cleared", 4'h4, 32'h0);

        // Start glitch: a 5-cycle low pulse is rejected
        @(negedge clk);
        RX = 1'b0;
        repeat (5) @(negedge clk);
        RX = 1'b1;
        repeat (40) @(negedge clk);
        check_reg("glitch_status", 4'h4, 32'h0);
        sb_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        read_rx("after_glitch");

        // rx_en cleared during bit 3 of a frame (0x99), which must not arrive
        part = 8'h99;
        @(negedge clk);
        RX = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX = part[i];
            repeat (BIT) @(negedge clk);
        end
        RX = part[3];
        repeat (6) @(negedge clk);
        bus_write(4'h0, 32'h0);
        repeat (BIT - 8) @(negedge clk);
        for (int i = 4; i < 8; i++) begin
            RX = part[i];
            repeat (BIT) @(negedge clk);
        end
        RX = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        bus_write(4'h0, 32'h3);
        check_reg("rxen_abort_status", 4'h4, 32'h0);
        sb_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        check_reg("rxen_next_status", 4'h4, 32'h1);
        read_rx("rxen_next_data");

`ifdef UART_RX_PARITY_EN
        // Even parity enabled
        bus_write(4'h0, 32'h7);
        check_reg("par_ctrl", 4'h0, 32'h7);
        sb_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1);
        check_reg("par_err_status", 4'h4, 32'h11);
        read_rx("par_err_data");
        bus_write(4'h4, 32'h10);
        check_reg("par_err_cleared", 4'h4, 32'h0);
        sb_q.push_back(8'h03);
        send_frame(8'h03, 1'b1, 1'b1, 1'b0);
        check_reg("par_ok_status", 4'h4, 32'h1);
        read_rx("par_ok_data");
`else
        // Without the parity build, CTRL[2] ignores writes
        bus_write(4'h0, 32'h7);
        check_reg("ctrl_no_parity", 4'h0, 32'h3);
        bus_write(4'h4, 32'h10);
        check_reg("status_no_parity", 4'h4, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
